// File: rtl/axi_vec_pkg.sv
// axi_vec_pkg: shared arbiter state encoding for the vector write arbiter
package axi_vec_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit at or above rr_ptr, wrapping
//   req    : request vector
//   rr_ptr : search start index
//   valid  : any request set
//   idx    : winning index
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[IW'((int'(rr_ptr) + i) % N)]) idx = IW'((int'(rr_ptr) + i) % N);
  end
endmodule

// File: rtl/axi_vector_write_arbiter.sv
// axi_vector_write_arbiter: round-robin arbiter handing one latched vector at a time to a vector writer
//   req/req_vec_length/req_vec/req_last : per-requester request and packed payload slices
//   done                                : one-cycle completion pulse to the served requester
//   busy, grant_idx                     : arbiter activity and current/last winner
//   wr_start/wr_vec_length/wr_vec/wr_last_write : command to the writer, held until next grant
//   wr_ready                            : writer completion pulse, honoured only while waiting
module axi_vector_write_arbiter
  import axi_vec_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int MAX_VEC_LENGTH   = 64,
  parameter int MAX_VEC_LENGTH_W = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1),
  parameter int IW               = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ*MAX_VEC_LENGTH_W-1:0]   req_vec_length,
  input  logic [NUM_REQ*MAX_VEC_LENGTH-1:0]     req_vec,
  input  logic [NUM_REQ-1:0]                    req_last,
  output logic [NUM_REQ-1:0]                    done,
  output logic                                  busy,
  output logic [IW-1:0]                         grant_idx,
  output logic                                  wr_start,
  output logic [MAX_VEC_LENGTH_W-1:0]           wr_vec_length,
  output logic [MAX_VEC_LENGTH-1:0]             wr_vec,
  output logic                                  wr_last_write,
  input  logic                                  wr_ready
);
  arb_state_t state, nxt;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic pick_valid;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  always_comb begin
    nxt = state == IDLE  ? (pick_valid ? START : IDLE) :
          state == START ? WAIT :
          state == WAIT  ? (wr_ready ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      wr_vec_length <= '0;
      wr_vec <= '0;
      wr_last_write <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && pick_valid) begin
        grant_idx <= pick_idx;
        wr_vec_length <= req_vec_length[pick_idx*MAX_VEC_LENGTH_W +: MAX_VEC_LENGTH_W];
        wr_vec <= req_vec[pick_idx*MAX_VEC_LENGTH +: MAX_VEC_LENGTH];
        wr_last_write <= req_last[pick_idx];
      end
      if (state == DONE) rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end
  assign busy = state != IDLE;
  assign wr_start = state == START;
  assign done = (state == DONE) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx : '0;
endmodule

// File: tb/tb_axi_vector_write_arbiter.sv
// tb_axi_vector_write_arbiter: scoreboard bench with a 32-bit-beat writer model
module tb_axi_vector_write_arbiter;
  logic clk = 0, rst_n = 0;
  logic [3:0] req = '0, req_last, done;
  logic [27:0] req_vec_length;
  logic [255:0] req_vec;
  logic busy, wr_start, wr_last_write, wr_ready;
  logic [1:0] grant_idx;
  logic [6:0] wr_vec_length;
  logic [63:0] wr_vec;
  logic [63:0] vec_s [4];
  logic [6:0] len_s [4];
  logic last_s [4];
  int checks = 0, errors = 0, start_cnt = 0, beat_cnt = 0;
  typedef struct packed {logic [1:0] idx; logic last;} grant_t;
  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  grant_t exp_grant [$];
  beat_t exp_beat [$];
  grant_t g;
  beat_t b;
  logic w_act = 0, tvalid = 0, tlast = 0;
  logic [31:0] tdata = '0;
  int w_beat = 0, w_beats = 0;
  always #5 clk = ~clk;
  always_comb begin
    req_vec = '0;
    req_vec_length = '0;
    req_last = '0;
    for (int i = 0; i < 4; i++) begin
      req_vec[i*64 +: 64] = vec_s[i];
      req_vec_length[i*7 +: 7] = len_s[i];
      req_last[i] = last_s[i];
    end
  end
  axi_vector_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_vec_length(req_vec_length), .req_vec(req_vec),
    .req_last(req_last), .done(done), .busy(busy), .grant_idx(grant_idx), .wr_start(wr_start),
    .wr_vec_length(wr_vec_length), .wr_vec(wr_vec), .wr_last_write(wr_last_write), .wr_ready(wr_ready)
  );
  initial wr_ready = 0;
  always @(posedge clk) begin
    wr_ready <= 0;
    tvalid <= 0;
    tlast <= 0;
    if (!rst_n) w_act <= 0;
    else if (wr_start) begin
      w_act <= 1;
      w_beat <= 0;
      w_beats <= (int'(wr_vec_length) + 31) / 32;
    end else if (w_act) begin
      if (w_beat < w_beats) begin
        tvalid <= 1;
        tdata <= wr_vec[w_beat*32 +: 32];
        tlast <= wr_last_write && (w_beat == w_beats - 1);
        w_beat <= w_beat + 1;
      end else begin
        wr_ready <= 1;
        w_act <= 0;
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    if (wr_start) start_cnt++;
    if (tvalid) begin
      beat_cnt++;
      if (exp_beat.size() == 0) check("extra_beat", 1, 0);
      else begin
        b = exp_beat.pop_front();
        check("tdata", tdata, b.data);
        check("tlast", tlast, b.last);
      end
    end
    if (|done) begin
      if (exp_grant.size() == 0) check("extra_done", done, 0);
      else begin
        g = exp_grant.pop_front();
        check("done", done, 4'b1 << g.idx);
        check("grant_idx", grant_idx, g.idx);
        check("wr_last_write", wr_last_write, g.last);
      end
    end
  end
  task automatic push_job(input int i);
    int n;
    n = (int'(len_s[i]) + 31) / 32;
    exp_grant.push_back('{idx: 2'(i), last: last_s[i]});
    for (int k = 0; k < n; k++) exp_beat.push_back('{data: vec_s[i][k*32 +: 32], last: last_s[i] && k == n - 1});
  endtask
  task automatic wait_dones(input int n, input bit drop);
    int k = 0;
    for (int c = 0; c < 100 * n && k < n; c++) begin
      @(negedge clk);
      if (|done) begin
        k++;
        if (drop) req = req & ~done;
      end
    end
    if (k < n) check("done_timeout", k, n);
  endtask
  task automatic wait_start();
    int c = 0;
    @(negedge clk);
    while (!wr_start && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!wr_start) check("start_timeout", 0, 1);
  endtask
  int s0, b0;
  initial begin
    for (int i = 0; i < 4; i++) begin
      vec_s[i] = {32'hC0DE_0000 | i, 32'h1111_1111 * (i + 1)};
      len_s[i] = 7'd32;
      last_s[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_start", wr_start, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_wr_vec", wr_vec, 0);
    check("rst_wr_len", wr_vec_length, 0);
    check("rst_wr_last", wr_last_write, 0);
    rst_n = 1;
    @(negedge clk);
    vec_s[2] = 64'hDEAD_BEEF_0123_4567;
    len_s[2] = 7'd40;
    s0 = start_cnt; b0 = beat_cnt;
    push_job(2);
    req = 4'b0100;
    wait_start();
    vec_s[2] = 64'h5555_AAAA_5555_AAAA;
    wait_dones(1, 1);
    @(negedge clk);
    check("s1_rr_ptr", dut.rr_ptr, 3);
    check("s1_starts", start_cnt - s0, 1);
    check("s1_beats", beat_cnt - b0, 2);
    check("s1_idle", busy, 0);
    rst_n = 0;
    len_s[0] = 7'd32; len_s[1] = 7'd8; len_s[2] = 7'd64; len_s[3] = 7'd0;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) push_job(i % 4);
    rst_n = 1;
    wait_dones(5, 0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    check("s2_starts", start_cnt - s0, 5);
    check("s2_rr_ptr", dut.rr_ptr, 1);
    len_s[1] = 7'd0;
    s0 = start_cnt; b0 = beat_cnt;
    push_job(1);
    req = 4'b0010;
    wait_dones(1, 1);
    @(negedge clk);
    check("s3_starts", start_cnt - s0, 1);
    check("s3_beats", beat_cnt - b0, 0);
    len_s[2] = 7'd8;
    push_job(2);
    req = 4'b0100;
    wait_dones(1, 1);
    @(negedge clk);
    check("s4_rr_ptr", dut.rr_ptr, 3);
    len_s[3] = 7'd64; last_s[3] = 1;
    len_s[0] = 7'd40; last_s[0] = 0;
    push_job(3);
    push_job(0);
    req = 4'b1001;
    wait_dones(2, 1);
    @(negedge clk);
    check("s4_req_clear", req, 0);
    len_s[2] = 7'd64;
    push_job(2);
    req = 4'b0100;
    wait_start();
    repeat (2) @(negedge clk);
    rst_n = 0;
    req = 4'b0000;
    exp_grant.delete();
    exp_beat.delete();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wr_start", wr_start, 0);
    check("abort_rr_ptr", dut.rr_ptr, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done, 0);
    len_s[0] = 7'd8; last_s[0] = 0;
    len_s[3] = 7'd8; last_s[3] = 1;
    push_job(0);
    push_job(3);
    req = 4'b1001;
    wait_dones(2, 1);
    repeat (3) @(negedge clk);
    check("leftover", exp_grant.size() + exp_beat.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
